// File: rtl/load_store_unit_if.sv
// Memory-side bus of the load/store unit: request channel out, ready/read-data in.
// Signal suffixes are named from the load/store unit's point of view.
interface load_store_unit_if #(
  parameter int DATAWIDTH = 32
);
  logic                   MemReq_o;
  logic                   MemWe_o;
  logic [DATAWIDTH-1:0]   MemAddr_o;
  logic [DATAWIDTH-1:0]   MemWData_o;
  logic [DATAWIDTH/8-1:0] MemBe_o;
  logic                   MemReady_i;
  logic                   MemRValid_i;
  logic [DATAWIDTH-1:0]   MemRData_i;

  modport master (
    output MemReq_o, MemWe_o, MemAddr_o, MemWData_o, MemBe_o,
    input  MemReady_i, MemRValid_i, MemRData_i
  );

  modport slave (
    input  MemReq_o, MemWe_o, MemAddr_o, MemWData_o, MemBe_o,
    output MemReady_i, MemRValid_i, MemRData_i
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: checks size/alignment, issues one word-addressed memory
// access per Start_i, lane-replicates store data and aligns/extends load data.
module load_store_unit #(
  parameter int DATAWIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 Start_i,
  input  logic                 MemWrite_i,
  input  logic [2:0]           Funct3_i,
  input  logic [DATAWIDTH-1:0] ALUResult_i,
  input  logic [DATAWIDTH-1:0] WriteData_i,
  output logic                 Busy_o,
  output logic                 Done_o,
  output logic                 Fault_o,
  output logic [DATAWIDTH-1:0] ReadData_o,
  load_store_unit_if.master    mem
);
  localparam int BE_W = DATAWIDTH / 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10,
    DONE = 2'b11
  } state_t;

  function automatic logic access_legal(input logic we, input logic [2:0] f3);
    logic ok;
    case (f3)
      3'b000, 3'b001, 3'b010: ok = 1'b1;
      3'b100, 3'b101:         ok = ~we;
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic bad;
    case (f3[1:0])
      2'b01:   bad = off[0];
      2'b10:   bad = (off != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

  function automatic logic [BE_W-1:0] store_be(input logic [2:0] f3, input logic [1:0] off);
    logic [BE_W-1:0] be;
    case (f3[1:0])
      2'b00:   be = {{(BE_W-1){1'b0}}, 1'b1} << off;
      2'b01:   be = {{(BE_W-2){1'b0}}, 2'b11} << off;
      default: be = {BE_W{1'b1}};
    endcase
    return be;
  endfunction

  function automatic logic [DATAWIDTH-1:0] store_wdata(input logic [2:0] f3,
                                                       input logic [DATAWIDTH-1:0] wd);
    logic [DATAWIDTH-1:0] d;
    case (f3[1:0])
      2'b00:   d = {(DATAWIDTH/8){wd[7:0]}};
      2'b01:   d = {(DATAWIDTH/16){wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  function automatic logic [DATAWIDTH-1:0] load_extract(input logic [2:0] f3,
                                                        input logic [1:0] off,
                                                        input logic [DATAWIDTH-1:0] rd);
    logic [7:0]           b;
    logic [15:0]          h;
    logic [DATAWIDTH-1:0] d;
    b = rd[{off, 3'b000} +: 8];
    h = rd[{off[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  d = {{(DATAWIDTH-8){b[7]}}, b};
      3'b001:  d = {{(DATAWIDTH-16){h[15]}}, h};
      3'b100:  d = {{(DATAWIDTH-8){1'b0}}, b};
      3'b101:  d = {{(DATAWIDTH-16){1'b0}}, h};
      default: d = rd;
    endcase
    return d;
  endfunction

  state_t               state_q, state_d;
  logic [2:0]           f3_q, f3_d;
  logic [1:0]           off_q, off_d;
  logic                 fault_q, fault_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 faulto_q, faulto_d;
  logic                 memreq_q, memreq_d;
  logic                 memwe_q, memwe_d;
  logic [DATAWIDTH-1:0] memaddr_q, memaddr_d;
  logic [DATAWIDTH-1:0] memwdata_q, memwdata_d;
  logic [BE_W-1:0]      membe_q, membe_d;
  logic [DATAWIDTH-1:0] rdata_q, rdata_d;

  // Next-state and next-output logic; outputs are derived from the next state so they register cleanly.
  always_comb begin
    state_d    = state_q;
    f3_d       = f3_q;
    off_d      = off_q;
    fault_d    = fault_q;
    memwe_d    = memwe_q;
    memaddr_d  = memaddr_q;
    memwdata_d = memwdata_q;
    membe_d    = membe_q;
    rdata_d    = rdata_q;
    case (state_q)
      IDLE: begin
        if (Start_i) begin
          f3_d  = Funct3_i;
          off_d = ALUResult_i[1:0];
          if (access_legal(MemWrite_i, Funct3_i) && !misaligned(Funct3_i, ALUResult_i[1:0])) begin
            state_d    = REQ;
            fault_d    = 1'b0;
            memwe_d    = MemWrite_i;
            memaddr_d  = {ALUResult_i[DATAWIDTH-1:2], 2'b00};
            membe_d    = MemWrite_i ? store_be(Funct3_i, ALUResult_i[1:0]) : {BE_W{1'b0}};
            memwdata_d = MemWrite_i ? store_wdata(Funct3_i, WriteData_i) : {DATAWIDTH{1'b0}};
          end else begin
            state_d = DONE;
            fault_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (mem.MemReady_i) begin
          state_d = memwe_q ? DONE : WAIT;
        end else begin
          state_d = REQ;
        end
      end
      WAIT: begin
        if (mem.MemRValid_i) begin
          rdata_d = load_extract(f3_q, off_q, mem.MemRData_i);
          state_d = DONE;
        end else begin
          state_d = WAIT;
        end
      end
      DONE: begin
        state_d = IDLE;
        fault_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == DONE);
    faulto_d = (state_d == DONE) && fault_d;
    memreq_d = (state_d == REQ);
  end

  // State and registered-output bank with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      f3_q       <= 3'b000;
      off_q      <= 2'b00;
      fault_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      faulto_q   <= 1'b0;
      memreq_q   <= 1'b0;
      memwe_q    <= 1'b0;
      memaddr_q  <= {DATAWIDTH{1'b0}};
      memwdata_q <= {DATAWIDTH{1'b0}};
      membe_q    <= {BE_W{1'b0}};
      rdata_q    <= {DATAWIDTH{1'b0}};
    end else begin
      state_q    <= state_d;
      f3_q       <= f3_d;
      off_q      <= off_d;
      fault_q    <= fault_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      faulto_q   <= faulto_d;
      memreq_q   <= memreq_d;
      memwe_q    <= memwe_d;
      memaddr_q  <= memaddr_d;
      memwdata_q <= memwdata_d;
      membe_q    <= membe_d;
      rdata_q    <= rdata_d;
    end
  end

  assign Busy_o         = busy_q;
  assign Done_o         = done_q;
  assign Fault_o        = faulto_q;
  assign ReadData_o     = rdata_q;
  assign mem.MemReq_o   = memreq_q;
  assign mem.MemWe_o    = memwe_q;
  assign mem.MemAddr_o  = memaddr_q;
  assign mem.MemWData_o = memwdata_q;
  assign mem.MemBe_o    = membe_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, stall/reset sequences and
// randomized accesses checked against an arithmetic reference model.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        Start;
  logic        MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic        Busy;
  logic        Done;
  logic        Fault;
  logic [31:0] ReadData;

  load_store_unit_if #(.DATAWIDTH(32)) mem_bus ();

  load_store_unit #(.DATAWIDTH(32)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .Start_i     (Start),
    .MemWrite_i  (MemWrite),
    .Funct3_i    (Funct3),
    .ALUResult_i (ALUResult),
    .WriteData_i (WriteData),
    .Busy_o      (Busy),
    .Done_o      (Done),
    .Fault_o     (Fault),
    .ReadData_o  (ReadData),
    .mem         (mem_bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_rd;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
    logic        fault;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs[20];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, "_busy"}, Busy, 1'b0);
    chk1({tag, "_done"}, Done, 1'b0);
    chk1({tag, "_fault"}, Fault, 1'b0);
    chk1({tag, "_req"}, mem_bus.MemReq_o, 1'b0);
    chk1({tag, "_we"}, mem_bus.MemWe_o, 1'b0);
    chk32({tag, "_be"}, {28'd0, mem_bus.MemBe_o}, 32'd0);
    chk32({tag, "_addr"}, mem_bus.MemAddr_o, 32'd0);
    chk32({tag, "_wdata"}, mem_bus.MemWData_o, 32'd0);
    chk32({tag, "_rdata"}, ReadData, 32'd0);
  endtask

  // Reference: size in bytes from funct3, byte offset from address, plain arithmetic.
  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [31:0] rdata,
                                output logic fault, output logic [3:0] be,
                                output logic [31:0] wdata, output logic [31:0] rdv);
    int     sz;
    int     off;
    logic   legal;
    longint v;
    sz    = 1 << f3[1:0];
    off   = int'(addr % 32'd4);
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    fault = !legal || ((off % sz) != 0);
    be    = we ? 4'(((1 << sz) - 1) << off) : 4'd0;
    if (sz == 1)      wdata = {24'd0, wd[7:0]} * 32'h01010101;
    else if (sz == 2) wdata = {16'd0, wd[15:0]} * 32'h00010001;
    else              wdata = wd;
    v = (longint'(rdata) >> (8 * off)) & ((64'sd1 << (8 * sz)) - 64'sd1);
    if (!f3[2] && sz < 4 && (((v >> (8 * sz - 1)) & 64'sd1) == 64'sd1))
      v = v - (64'sd1 << (8 * sz));
    rdv = v[31:0];
  endfunction

  task automatic run_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] rdata,
                            input int rdy_dly, input int rv_dly,
                            input logic exp_fault, input logic [3:0] exp_be,
                            input logic [31:0] exp_wdata, input logic [31:0] exp_rdv,
                            input logic noise, input string tag);
    logic [31:0] waddr;
    waddr = {addr[31:2], 2'b00};
    Start = 1'b1; MemWrite = we; Funct3 = f3; ALUResult = addr; WriteData = wd;
    step();
    Start = 1'b0;
    if (exp_fault) begin
      chk1({tag, "_fdone"}, Done, 1'b1);
      chk1({tag, "_ffault"}, Fault, 1'b1);
      chk1({tag, "_freq"}, mem_bus.MemReq_o, 1'b0);
      chk32({tag, "_frd"}, ReadData, exp_rd);
      step();
      chk1({tag, "_fdone2"}, Done, 1'b0);
      chk1({tag, "_freq2"}, mem_bus.MemReq_o, 1'b0);
      chk1({tag, "_fbusy2"}, Busy, 1'b0);
    end else begin
      chk1({tag, "_req"}, mem_bus.MemReq_o, 1'b1);
      chk1({tag, "_busy"}, Busy, 1'b1);
      chk1({tag, "_done0"}, Done, 1'b0);
      chk1({tag, "_we"}, mem_bus.MemWe_o, we);
      chk32({tag, "_addr"}, mem_bus.MemAddr_o, waddr);
      chk32({tag, "_be"}, {28'd0, mem_bus.MemBe_o}, {28'd0, exp_be});
      if (we) chk32({tag, "_wdata"}, mem_bus.MemWData_o, exp_wdata);
      for (int k = 0; k < rdy_dly; k++) begin
        if (noise) begin
          Start = 1'b1; MemWrite = ~we; ALUResult = $urandom; Funct3 = 3'($urandom);
          mem_bus.MemRValid_i = 1'b1; mem_bus.MemRData_i = $urandom;
        end
        step();
        Start = 1'b0; mem_bus.MemRValid_i = 1'b0;
        chk1({tag, "_sreq"}, mem_bus.MemReq_o, 1'b1);
        chk1({tag, "_swe"}, mem_bus.MemWe_o, we);
        chk32({tag, "_saddr"}, mem_bus.MemAddr_o, waddr);
        chk32({tag, "_sbe"}, {28'd0, mem_bus.MemBe_o}, {28'd0, exp_be});
        if (we) chk32({tag, "_swdata"}, mem_bus.MemWData_o, exp_wdata);
        chk1({tag, "_sdone"}, Done, 1'b0);
        chk32({tag, "_srd"}, ReadData, exp_rd);
      end
      mem_bus.MemReady_i = 1'b1;
      step();
      mem_bus.MemReady_i = 1'b0;
      if (we) begin
        chk1({tag, "_wdone"}, Done, 1'b1);
        chk1({tag, "_wfault"}, Fault, 1'b0);
        chk1({tag, "_wreq"}, mem_bus.MemReq_o, 1'b0);
        chk32({tag, "_wrd"}, ReadData, exp_rd);
      end else begin
        chk1({tag, "_ldone0"}, Done, 1'b0);
        chk1({tag, "_lbusy"}, Busy, 1'b1);
        chk1({tag, "_lreq"}, mem_bus.MemReq_o, 1'b0);
        for (int k = 0; k < rv_dly; k++) begin
          if (noise) begin
            Start = 1'b1; MemWrite = $urandom_range(0, 1) == 1; ALUResult = $urandom;
          end
          step();
          Start = 1'b0;
          chk1({tag, "_wdone_w"}, Done, 1'b0);
          chk1({tag, "_wbusy_w"}, Busy, 1'b1);
          chk32({tag, "_wrd_w"}, ReadData, exp_rd);
        end
        mem_bus.MemRValid_i = 1'b1; mem_bus.MemRData_i = rdata;
        step();
        mem_bus.MemRValid_i = 1'b0; mem_bus.MemRData_i = $urandom;
        exp_rd = exp_rdv;
        chk1({tag, "_ldone"}, Done, 1'b1);
        chk1({tag, "_lfault"}, Fault, 1'b0);
        chk32({tag, "_lrd"}, ReadData, exp_rd);
      end
      step();
      chk1({tag, "_edone"}, Done, 1'b0);
      chk1({tag, "_ebusy"}, Busy, 1'b0);
      chk1({tag, "_efault"}, Fault, 1'b0);
    end
  endtask

  initial begin
    logic        m_fault;
    logic [3:0]  m_be;
    logic [31:0] m_wdata;
    logic [31:0] m_rd;
    logic        r_we;
    logic [2:0]  r_f3;
    logic [31:0] r_addr, r_wd, r_rdata;

    //            we    f3      addr        wd            rdata         flt   be     wdata         rd
    vecs[0]  = '{1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,        1'b0, 4'hF, 32'hDEADBEEF, 32'h0};
    vecs[1]  = '{1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0,        1'b0, 4'h8, 32'hA5A5A5A5, 32'h0};
    vecs[2]  = '{1'b1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0,        1'b0, 4'hC, 32'hABCDABCD, 32'h0};
    vecs[3]  = '{1'b1, 3'b001, 32'h101, 32'h1234ABCD, 32'h0,        1'b1, 4'h0, 32'h0,        32'h0};
    vecs[4]  = '{1'b1, 3'b010, 32'h102, 32'h1234ABCD, 32'h0,        1'b1, 4'h0, 32'h0,        32'h0};
    vecs[5]  = '{1'b1, 3'b011, 32'h100, 32'h1234ABCD, 32'h0,        1'b1, 4'h0, 32'h0,        32'h0};
    vecs[6]  = '{1'b1, 3'b100, 32'h100, 32'h1234ABCD, 32'h0,        1'b1, 4'h0, 32'h0,        32'h0};
    vecs[7]  = '{1'b0, 3'b000, 32'h102, 32'h0,        32'h1280FF34, 1'b0, 4'h0, 32'h0,        32'hFFFFFF80};
    vecs[8]  = '{1'b0, 3'b100, 32'h102, 32'h0,        32'h1280FF34, 1'b0, 4'h0, 32'h0,        32'h00000080};
    vecs[9]  = '{1'b0, 3'b001, 32'h102, 32'h0,        32'h1280FF34, 1'b0, 4'h0, 32'h0,        32'h00001280};
    vecs[10] = '{1'b0, 3'b010, 32'h101, 32'h0,        32'h1280FF34, 1'b1, 4'h0, 32'h0,        32'h0};
    vecs[11] = '{1'b0, 3'b011, 32'h100, 32'h0,        32'h1280FF34, 1'b1, 4'h0, 32'h0,        32'h0};
    vecs[12] = '{1'b0, 3'b101, 32'h100, 32'h0,        32'h1280FF34, 1'b0, 4'h0, 32'h0,        32'h0000FF34};
    vecs[13] = '{1'b0, 3'b001, 32'h100, 32'h0,        32'h1280FF34, 1'b0, 4'h0, 32'h0,        32'hFFFFFF34};
    vecs[14] = '{1'b0, 3'b000, 32'h101, 32'h0,        32'h1280FF34, 1'b0, 4'h0, 32'h0,        32'hFFFFFFFF};
    vecs[15] = '{1'b0, 3'b100, 32'h103, 32'h0,        32'h1280FF34, 1'b0, 4'h0, 32'h0,        32'h00000012};
    vecs[16] = '{1'b0, 3'b010, 32'h104, 32'h0,        32'h1280FF34, 1'b0, 4'h0, 32'h0,        32'h1280FF34};
    vecs[17] = '{1'b0, 3'b110, 32'h100, 32'h0,        32'h1280FF34, 1'b1, 4'h0, 32'h0,        32'h0};
    vecs[18] = '{1'b1, 3'b000, 32'h100, 32'h00000077, 32'h0,        1'b0, 4'h1, 32'h77777777, 32'h0};
    vecs[19] = '{1'b0, 3'b010, 32'h108, 32'h0,        32'h80000001, 1'b0, 4'h0, 32'h0,        32'h80000001};

    rst_n = 1'b0; Start = 1'b0; MemWrite = 1'b0; Funct3 = 3'b000;
    ALUResult = 32'd0; WriteData = 32'd0;
    mem_bus.MemReady_i = 1'b0; mem_bus.MemRValid_i = 1'b0; mem_bus.MemRData_i = 32'd0;
    exp_rd = 32'd0;
    step(); step();
    chk_all_zero("reset");
    rst_n = 1'b1;
    step();
    chk_all_zero("idle");

    for (int i = 0; i < 20; i++) begin
      run_access(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wd, vecs[i].rdata, 0, 0,
                 vecs[i].fault, vecs[i].be, vecs[i].wdata, vecs[i].rd, 1'b0,
                 $sformatf("vec%0d", i));
    end

    // Stalled load: ready low 3 cycles, data 2 cycles later, stray Start/RValid meanwhile.
    run_access(1'b0, 3'b010, 32'h200, 32'h0, 32'hCAFEF00D, 3, 2, 1'b0, 4'h0, 32'h0,
               32'hCAFEF00D, 1'b1, "stall_ld");
    step();
    chk1("stall_noqueue_busy", Busy, 1'b0);
    chk1("stall_noqueue_done", Done, 1'b0);
    run_access(1'b1, 3'b001, 32'h2002, 32'h0000BEEF, 32'h0, 2, 0, 1'b0, 4'hC, 32'hBEEFBEEF,
               32'h0, 1'b1, "stall_st");

    // Reset while waiting for load data; the late data must be ignored.
    Start = 1'b1; MemWrite = 1'b0; Funct3 = 3'b010; ALUResult = 32'h300;
    step();
    Start = 1'b0; mem_bus.MemReady_i = 1'b1;
    step();
    mem_bus.MemReady_i = 1'b0;
    chk1("rstwait_busy", Busy, 1'b1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; mem_bus.MemRValid_i = 1'b1; mem_bus.MemRData_i = 32'h12345678;
    step();
    mem_bus.MemRValid_i = 1'b0;
    chk_all_zero("rstwait_a");
    step();
    chk_all_zero("rstwait_b");
    exp_rd = 32'd0;

    for (int n = 0; n < 250; n++) begin
      r_we    = $urandom_range(0, 1) == 1;
      r_f3    = 3'($urandom);
      r_addr  = $urandom;
      r_wd    = $urandom;
      r_rdata = $urandom;
      model(r_we, r_f3, r_addr, r_wd, r_rdata, m_fault, m_be, m_wdata, m_rd);
      run_access(r_we, r_f3, r_addr, r_wd, r_rdata, $urandom_range(0, 2), $urandom_range(0, 2),
                 m_fault, m_be, m_wdata, m_rd, $urandom_range(0, 1) == 1, $sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
